// File: rtl/breathing_pwm_multi.sv
// Multi-channel breathing LED driver: one shared triangle phase, per-channel offsets,
// optional square-law shaping, and frame-synchronous PWM with registered outputs.
module breathing_pwm_multi #(
  parameter int CH       = 4,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 97656,
  parameter int GAMMA_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2*CH-1:0]   mode,
  input  logic              pause,
  input  logic              sync,
  output logic [CH-1:0]     light,
  output logic              frame_start
);

  localparam int PW       = PWM_BITS + 1;
  localparam int PSW      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int PH_STEP  = (1 << PW) / CH;
  localparam logic [PSW-1:0]      PS_MAX  = PSW'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    M_OFF     = 2'd0,
    M_ON      = 2'd1,
    M_BREATHE = 2'd2,
    M_BLINK   = 2'd3
  } mode_t;

  logic [PSW-1:0]      presc_reg;
  logic [PW-1:0]       phase_reg;
  logic [PWM_BITS-1:0] cnt_reg;
  logic                step_tick;
  logic                wrap;

  assign step_tick = (presc_reg == PS_MAX);
  assign wrap      = (cnt_reg == CNT_MAX);

  // sync overrides both the tick and pause
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
      phase_reg <= '0;
    end else if (sync) begin
      presc_reg <= '0;
      phase_reg <= '0;
    end else begin
      presc_reg <= step_tick ? '0 : presc_reg + 1'b1;
      if (step_tick && !pause)
        phase_reg <= phase_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg     <= '0;
      frame_start <= 1'b0;
    end else begin
      cnt_reg     <= cnt_reg + 1'b1;
      frame_start <= wrap;
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    localparam logic [PW-1:0] OFFS = PW'(gi * PH_STEP);

    logic [PW-1:0]         ch_phase;
    logic [PWM_BITS-1:0]   level;
    logic [2*PWM_BITS-1:0] level_w;
    logic [2*PWM_BITS-1:0] sq;
    logic [PWM_BITS-1:0]   shaped;
    mode_t                 mode_now;
    mode_t                 mode_reg;
    logic [PWM_BITS-1:0]   duty_reg;
    logic                  light_reg;

    assign mode_now = mode_t'(mode[2*gi +: 2]);
    assign ch_phase = phase_reg + OFFS;
    // falling half mirrors the rising half: (2^N-1) - x == ~x
    assign level    = ch_phase[PW-1] ? ~ch_phase[PWM_BITS-1:0] : ch_phase[PWM_BITS-1:0];
    assign level_w  = {{PWM_BITS{1'b0}}, level};
    assign sq       = level_w * level_w;
    assign shaped   = (GAMMA_EN != 0) ? PWM_BITS'(sq >> PWM_BITS) : level;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mode_reg  <= M_OFF;
        duty_reg  <= '0;
        light_reg <= 1'b0;
      end else begin
        if (wrap) begin
          mode_reg <= mode_now;
          case (mode_now)
            M_BREATHE: duty_reg <= shaped;
            M_BLINK:   duty_reg <= ch_phase[PW-1] ? '0 : '1;
            default:   duty_reg <= '0;
          endcase
        end
        // BLINK is all-or-nothing per frame, so it bypasses the comparator
        case (mode_reg)
          M_ON:      light_reg <= 1'b1;
          M_BREATHE: light_reg <= (cnt_reg < duty_reg);
          M_BLINK:   light_reg <= duty_reg[PWM_BITS-1];
          default:   light_reg <= 1'b0;
        endcase
      end
    end

    assign light[gi] = light_reg;
  end

endmodule

// File: tb/tb_breathing_pwm_multi.sv
// Bench for breathing_pwm_multi: CH=2, PWM_BITS=4, STEP_DIV=2, with GAMMA_EN=0 and 1 instances.
module tb_breathing_pwm_multi;

  localparam int STEP_DIV = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mode;
  logic       pause;
  logic       sync;
  logic [1:0] light0, light1;
  logic       fs0, fs1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  breathing_pwm_multi #(.CH(2), .PWM_BITS(4), .STEP_DIV(STEP_DIV), .GAMMA_EN(0)) dut0 (
    .clk(clk), .rst(rst), .mode(mode), .pause(pause), .sync(sync),
    .light(light0), .frame_start(fs0)
  );

  breathing_pwm_multi #(.CH(2), .PWM_BITS(4), .STEP_DIV(STEP_DIV), .GAMMA_EN(1)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .pause(pause), .sync(sync),
    .light(light1), .frame_start(fs1)
  );

  // Behavioural model. Duty is the number of lit clocks per frame (0..16);
  // BLINK-on is simply a duty of 16.
  int m_presc, m_phase, m_cnt;
  int m_lmode [2];
  int m_lduty [2][2];
  bit m_light [2][2];
  bit m_fs;

  function automatic int duty_of(input int md, input int ph, input int k, input int g);
    int cp, lvl;
    cp  = (ph + k * 16) % 32;
    lvl = (cp < 16) ? cp : 31 - cp;
    if (md == 2) return (g != 0) ? (lvl * lvl) / 16 : lvl;
    if (md == 3) return (cp < 16) ? 16 : 0;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_presc <= 0;
      m_phase <= 0;
      m_cnt   <= 0;
      m_fs    <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_lmode[k] <= 0;
        for (int g = 0; g < 2; g++) begin
          m_lduty[g][k] <= 0;
          m_light[g][k] <= 1'b0;
        end
      end
    end else begin
      if (sync) begin
        m_presc <= 0;
        m_phase <= 0;
      end else begin
        m_presc <= (m_presc + 1) % STEP_DIV;
        if (m_presc == STEP_DIV - 1 && !pause) m_phase <= (m_phase + 1) % 32;
      end
      m_cnt <= (m_cnt + 1) % 16;
      m_fs  <= (m_cnt == 15);
      for (int k = 0; k < 2; k++) begin
        for (int g = 0; g < 2; g++)
          m_light[g][k] <= (m_lmode[k] == 1) || (m_lmode[k] >= 2 && m_cnt < m_lduty[g][k]);
        if (m_cnt == 15) begin
          m_lmode[k] <= int'(mode[2*k +: 2]);
          for (int g = 0; g < 2; g++)
            m_lduty[g][k] <= duty_of(int'(mode[2*k +: 2]), m_phase, k, g);
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    checks++;
    if (light0 !== {m_light[0][1], m_light[0][0]}) begin
      failures++;
      $display("FAIL light_g0 t=%0t actual=%b expected=%b", $time, light0, {m_light[0][1], m_light[0][0]});
    end
    checks++;
    if (light1 !== {m_light[1][1], m_light[1][0]}) begin
      failures++;
      $display("FAIL light_g1 t=%0t actual=%b expected=%b", $time, light1, {m_light[1][1], m_light[1][0]});
    end
    checks++;
    if (fs0 !== m_fs || fs1 !== m_fs) begin
      failures++;
      $display("FAIL frame_start t=%0t actual=%b/%b expected=%b", $time, fs0, fs1, m_fs);
    end
  end

  task automatic expect_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end else begin
      $display("check %s value=%0d ok", name, act);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic count_high(input int g, input int k, output int n);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if ((g == 0) ? light0[k] : light1[k]) n++;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic wait_phase(input int p, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (m_phase == p) break;
      step(1);
    end
    expect_eq($sformatf("reach_phase_%0d", p), m_phase, p);
  endtask

  task automatic first_frame_start(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (fs0) break;
    end
    expect_eq(name, n, 16);
    #1;
  endtask

  int n;

  initial begin
    rst = 1'b1; mode = 4'b0000; pause = 1'b0; sync = 1'b0;
    step(3);
    expect_eq("reset_light", int'(light0), 0);
    expect_eq("reset_fs", int'(fs0), 0);

    // Both channels ON; first latch at first wrap
    mode = 4'b0101;
    rst  = 1'b0;
    first_frame_start("first_fs_after_reset");
    expect_eq("on_before_latch", int'(light0), 0);
    step(48);
    expect_eq("on_steady", int'(light0), 3);
    mode = 4'b0000;
    step(40);
    expect_eq("off_steady", int'(light0), 0);

    // BREATHE, phase frozen at 5
    mode = 4'b1010;
    sync = 1'b1; step(1); sync = 1'b0;
    wait_phase(5, 50);
    pause = 1'b1;
    step(40);
    count_high(0, 0, n); expect_eq("breathe_ph5_ch0", n, 5);
    count_high(0, 1, n); expect_eq("breathe_ph5_ch1", n, 10);
    count_high(1, 0, n); expect_eq("gamma_ph5_ch0", n, 1);
    count_high(1, 1, n); expect_eq("gamma_ph5_ch1", n, 6);

    // Gamma shaping at level 15 and level 3
    pause = 1'b0;
    wait_phase(15, 60);
    pause = 1'b1;
    step(40);
    count_high(1, 0, n); expect_eq("gamma_lvl15_ch0", n, 14);
    count_high(1, 1, n); expect_eq("gamma_lvl0_ch1", n, 0);
    count_high(0, 0, n); expect_eq("linear_lvl15_ch0", n, 15);
    pause = 1'b0;
    wait_phase(3, 100);
    pause = 1'b1;
    step(40);
    count_high(1, 0, n); expect_eq("gamma_lvl3_ch0", n, 0);
    count_high(1, 1, n); expect_eq("gamma_lvl12_ch1", n, 9);

    // sync coincident with a step tick while paused
    for (int i = 0; i < 10; i++) begin
      if (m_presc == STEP_DIV - 1) break;
      step(1);
    end
    expect_eq("presc_at_tick", m_presc, STEP_DIV - 1);
    sync = 1'b1; step(1); sync = 1'b0;
    expect_eq("sync_phase", int'(dut0.phase_reg), 0);
    expect_eq("sync_presc", int'(dut0.presc_reg), 0);
    expect_eq("model_sync_phase", m_phase, 0);
    pause = 1'b0;
    step(2);
    expect_eq("phase_after_sync_tick", int'(dut0.phase_reg), 1);

    // BLINK across the 31 -> 0 phase wrap
    mode = 4'b0011;
    step(80);
    wait_phase(31, 80);
    pause = 1'b1;
    step(40);
    count_high(0, 0, n); expect_eq("blink_ph31_ch0", n, 0);
    pause = 1'b0;
    step(2);
    expect_eq("phase_wrapped", m_phase, 0);
    pause = 1'b1;
    step(40);
    count_high(0, 0, n); expect_eq("blink_ph0_ch0", n, 16);
    count_high(1, 0, n); expect_eq("blink_ph0_ch0_gamma", n, 16);

    // Asynchronous reset mid-frame with lights on
    mode = 4'b0101;
    step(40);
    expect_eq("on_before_rst", int'(light0), 3);
    rst = 1'b1;
    #1;
    expect_eq("rst_async_light0", int'(light0), 0);
    expect_eq("rst_async_light1", int'(light1), 0);
    step(2);
    rst = 1'b0;
    step(8);
    expect_eq("post_rst_before_latch", int'(light0), 0);
    step(20);
    expect_eq("post_rst_on", int'(light0), 3);
    rst = 1'b1; step(1); rst = 1'b0;
    first_frame_start("first_fs_after_rst_pulse");
    step(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/breathing_pwm_multi.md
BREATHING_PWM_MULTI -- requirements
Module: breathing_pwm_multi

Interface
REQ-001 Parameter CH, default 4, number of independent LED channels; SHALL be a power of two, 1..16.
REQ-002 Parameter PWM_BITS, default 8, PWM counter/duty width; PWM frame = 2^PWM_BITS clocks.
REQ-003 Parameter STEP_DIV, default 97656, clocks per brightness step; SHALL be >= 1.
REQ-004 Parameter GAMMA_EN, default 1, enables square-law brightness shaping.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 mode  input  2*CH  per-channel mode, channel k in bits [2k+1:2k]: 0 OFF, 1 ON, 2 BREATHE, 3 BLINK.
REQ-008 pause  input  1  while high, phase stepping is frozen; PWM keeps running.
REQ-009 sync  input  1  single-cycle pulse; restarts the shared phase.
REQ-010 light  output  CH  per-channel PWM LED drive.
REQ-011 frame_start  output  1  one-cycle pulse marking the first clock of each PWM frame.

Function
REQ-012 Prescaler SHALL count 0..STEP_DIV-1 and wrap; step tick SHALL assert on the cycle it equals STEP_DIV-1.
REQ-013 Shared phase counter, PWM_BITS+1 bits, SHALL increment by 1 on each step tick while pause=0 and wrap from all-ones to 0.
REQ-014 sync=1 SHALL clear prescaler and phase to 0 on the next edge; sync SHALL win over a simultaneous step tick and over pause.
REQ-015 Channel k phase SHALL be phase + k*2^(PWM_BITS+1)/CH, modulo 2^(PWM_BITS+1).
REQ-016 Triangle level: channel phase MSB=0 -> level = low PWM_BITS bits; MSB=1 -> level = (2^PWM_BITS-1) - low bits.
REQ-017 GAMMA_EN=1 -> shaped = (level*level) >> PWM_BITS, computed at full 2*PWM_BITS width, no overflow; GAMMA_EN=0 -> shaped = level.
REQ-018 PWM counter, PWM_BITS bits, SHALL increment every clock and wrap from 2^PWM_BITS-1 to 0.
REQ-019 Per-channel duty register and latched mode SHALL update only on the edge where the PWM counter wraps to 0; mode or phase changes mid-frame SHALL NOT affect the current frame.
REQ-020 Latched duty: BREATHE -> shaped; BLINK -> all-ones if channel phase MSB=0 else 0; ON/OFF -> don't-care.
REQ-021 light[k] SHALL be registered: OFF -> 0; ON -> 1 continuously; BREATHE/BLINK -> 1 when PWM counter < duty, else 0; one clock latency from counter value to light.
REQ-022 BLINK high phase SHALL use forced 1 for the whole frame (not 2^PWM_BITS-1 of 2^PWM_BITS).
REQ-023 Duty 0 SHALL yield light=0 for the whole frame, no single-cycle glitch.
REQ-024 frame_start SHALL be registered, high during the cycle PWM counter = 0.
REQ-025 Channels SHALL be generated by a loop over CH; no channel-specific hand logic.

Reset
REQ-026 While rst=1: prescaler, phase, PWM counter, all duty and latched-mode registers = 0; light = 0; frame_start = 0.
REQ-027 Release of rst SHALL start the PWM counter at 0 on the first edge; first duty latch occurs at the first wrap.
REQ-028 rst asserted mid-frame SHALL force light=0 immediately (asynchronously), without waiting for a clock.

Verification (CH=2, PWM_BITS=4, STEP_DIV=2, GAMMA_EN=0 unless noted)
REQ-029 mode=ON for both, run 64 clocks -> light=2'b11 constantly from the second frame; mode=OFF -> 2'b00 from the next frame, not before.
REQ-030 ch0 BREATHE, phase held at 5 via pause -> light[0] high exactly 5 of every 16 clocks; ch1 (phase 5+16=21, falling: level 15-5=10) high 10 of 16.
REQ-031 GAMMA_EN=1, level 15 -> duty 14 (225>>4), light high 14/16 clocks; level 3 -> duty 0, light stays 0 entire frame.
REQ-032 sync asserted same cycle as step tick with pause=1 -> phase=0 next cycle, prescaler=0; following tick increments to 1.
REQ-033 Phase wrap 31->0 on a step tick -> ch0 level 0->0 (15-15=0 then 0), no discontinuity; BLINK ch0 toggles forced 0 -> forced 1 at next frame boundary.
REQ-034 rst pulse mid-frame with light=1 -> light=0 before next clock edge; after release, frame_start first pulses when counter=0 and duties latch at the first wrap.
